// File: rtl/he_mul_sequencer.sv
// Control FSM sequencing one homomorphic multiply: clear, load A/B rows, drain, write results.
// Optional completed-operation counter enabled by defining HE_SEQ_OP_COUNT_EN.
module he_mul_sequencer #(
  parameter int CIPHERTEXT_WIDTH = 6,
  parameter int DIMENSION        = 1,
  parameter int ROW_WIDTH        = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  output logic                        opnd_rd_en,
  output logic                        opnd_rd_sel,
  output logic [ROW_WIDTH-1:0]        opnd_rd_row,
  input  logic [CIPHERTEXT_WIDTH-1:0] opnd_rd_data,
  output logic                        mul_clear,
  output logic                        mul_en,
  output logic [ROW_WIDTH-1:0]        mul_row,
  output logic                        mul_ciphertext_select,
  output logic [CIPHERTEXT_WIDTH-1:0] mul_ciphertext_entry,
  input  logic [CIPHERTEXT_WIDTH-1:0] mul_result_partial,
  output logic                        res_wr_en,
  output logic [ROW_WIDTH-1:0]        res_wr_row,
  output logic [CIPHERTEXT_WIDTH-1:0] res_wr_data,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 op_count
);

  localparam logic [ROW_WIDTH-1:0] D_ROW = ROW_WIDTH'(DIMENSION);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_A, LOAD_B, DRAIN, FLUSH, DONE} state_t;

  state_t               state;
  logic [ROW_WIDTH-1:0] cnt;
  logic                 fwd;
  logic                 drain_issue;
  logic [ROW_WIDTH-1:0] drain_row;
  logic                 wr_next;

  // Data inputs are only valid one cycle after the strobe that requested them
  assign mul_ciphertext_entry = fwd ? opnd_rd_data : {CIPHERTEXT_WIDTH{1'b0}};
  assign res_wr_data          = res_wr_en ? mul_result_partial : {CIPHERTEXT_WIDTH{1'b0}};

  // Drain issue and result-write qualification decoded from current state and pipeline
  always_comb begin
    drain_issue = 1'b0;
    drain_row   = {ROW_WIDTH{1'b0}};
    wr_next     = 1'b0;
    if (state == DRAIN && cnt != D_ROW) begin
      drain_issue = 1'b1;
      drain_row   = D_ROW + cnt + ROW_WIDTH'(1);
    end else begin
      drain_issue = 1'b0;
    end
    // B rows and upper tensor rows each produce a result row; A rows do not
    if (mul_en && (mul_ciphertext_select || mul_row > D_ROW)) begin
      wr_next = 1'b1;
    end else begin
      wr_next = 1'b0;
    end
  end

  // Sequencing FSM with registered strobes and one-cycle multiplier/result pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      cnt                   <= {ROW_WIDTH{1'b0}};
      fwd                   <= 1'b0;
      opnd_rd_en            <= 1'b0;
      opnd_rd_sel           <= 1'b0;
      opnd_rd_row           <= {ROW_WIDTH{1'b0}};
      mul_clear             <= 1'b0;
      mul_en                <= 1'b0;
      mul_row               <= {ROW_WIDTH{1'b0}};
      mul_ciphertext_select <= 1'b0;
      res_wr_en             <= 1'b0;
      res_wr_row            <= {ROW_WIDTH{1'b0}};
      busy                  <= 1'b0;
      done                  <= 1'b0;
    end else begin
      mul_clear             <= 1'b0;
      done                  <= 1'b0;
      opnd_rd_en            <= 1'b0;
      opnd_rd_sel           <= 1'b0;
      opnd_rd_row           <= {ROW_WIDTH{1'b0}};
      fwd                   <= opnd_rd_en;
      mul_en                <= opnd_rd_en | drain_issue;
      mul_row               <= drain_issue ? drain_row : (opnd_rd_en ? opnd_rd_row : {ROW_WIDTH{1'b0}});
      mul_ciphertext_select <= opnd_rd_en & opnd_rd_sel;
      res_wr_en             <= wr_next;
      res_wr_row            <= wr_next ? mul_row : {ROW_WIDTH{1'b0}};
      if (abort && state != IDLE) begin
        state                 <= IDLE;
        cnt                   <= {ROW_WIDTH{1'b0}};
        busy                  <= 1'b0;
        mul_clear             <= 1'b1;
        fwd                   <= 1'b0;
        mul_en                <= 1'b0;
        mul_row               <= {ROW_WIDTH{1'b0}};
        mul_ciphertext_select <= 1'b0;
        res_wr_en             <= 1'b0;
        res_wr_row            <= {ROW_WIDTH{1'b0}};
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state     <= CLEAR;
              busy      <= 1'b1;
              mul_clear <= 1'b1;
            end else begin
              busy <= 1'b0;
            end
          end
          CLEAR: begin
            state       <= LOAD_A;
            cnt         <= {ROW_WIDTH{1'b0}};
            opnd_rd_en  <= 1'b1;
          end
          LOAD_A: begin
            opnd_rd_en <= 1'b1;
            if (cnt == D_ROW) begin
              state       <= LOAD_B;
              cnt         <= {ROW_WIDTH{1'b0}};
              opnd_rd_sel <= 1'b1;
            end else begin
              cnt         <= cnt + ROW_WIDTH'(1);
              opnd_rd_row <= cnt + ROW_WIDTH'(1);
            end
          end
          LOAD_B: begin
            if (cnt == D_ROW) begin
              state <= DRAIN;
              cnt   <= {ROW_WIDTH{1'b0}};
            end else begin
              cnt         <= cnt + ROW_WIDTH'(1);
              opnd_rd_en  <= 1'b1;
              opnd_rd_sel <= 1'b1;
              opnd_rd_row <= cnt + ROW_WIDTH'(1);
            end
          end
          // First DRAIN cycle carries the last B row through the pipeline
          DRAIN: begin
            if (cnt == D_ROW) begin
              state <= FLUSH;
              cnt   <= {ROW_WIDTH{1'b0}};
            end else begin
              cnt <= cnt + ROW_WIDTH'(1);
            end
          end
          FLUSH: begin
            state <= DONE;
            done  <= 1'b1;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= {ROW_WIDTH{1'b0}};
          end
        endcase
      end
    end
  end

`ifdef HE_SEQ_OP_COUNT_EN
  logic [15:0] op_count_r;

  // Saturating count of operations that reached done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_r <= 16'h0000;
    end else if (state == FLUSH && !abort && op_count_r != 16'hFFFF) begin
      op_count_r <= op_count_r + 16'h0001;
    end else begin
      op_count_r <= op_count_r;
    end
  end

  assign op_count = op_count_r;
`else
  assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_he_mul_sequencer.sv
// Directed bench for he_mul_sequencer (D=1) with an operand buffer and tensor-product multiplier model.
module tb_he_mul_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       opnd_rd_en, opnd_rd_sel, mul_clear, mul_en, mul_sel;
  logic [1:0] opnd_rd_row, mul_row, res_wr_row;
  logic [5:0] opnd_rd_data, mul_entry, mul_res, res_wr_data;
  logic       res_wr_en, busy, done;
  logic [15:0] op_count;

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;
  int done_base;
  logic [15:0] op_exp = 16'h0000;

  logic [5:0] buf_a [0:1];
  logic [5:0] buf_b [0:1];
  logic [5:0] ma [0:1];
  logic [5:0] mb [0:1];

  always #5 clk = ~clk;

  he_mul_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .opnd_rd_en(opnd_rd_en), .opnd_rd_sel(opnd_rd_sel), .opnd_rd_row(opnd_rd_row),
    .opnd_rd_data(opnd_rd_data), .mul_clear(mul_clear), .mul_en(mul_en), .mul_row(mul_row),
    .mul_ciphertext_select(mul_sel), .mul_ciphertext_entry(mul_entry),
    .mul_result_partial(mul_res), .res_wr_en(res_wr_en), .res_wr_row(res_wr_row),
    .res_wr_data(res_wr_data), .busy(busy), .done(done), .op_count(op_count)
  );

  // Tensor row r = sum of a_i*b_j over i+j=r, modulo 2^6
  function automatic logic [5:0] conv(input logic [1:0] r, input logic [5:0] a0, a1, b0, b1);
    case (r)
      2'd0:    return 6'(a0 * b0);
      2'd1:    return 6'(a0 * b1 + a1 * b0);
      2'd2:    return 6'(a1 * b1);
      default: return 6'd0;
    endcase
  endfunction

  // Registered operand buffer: data one cycle after the read strobe
  always @(posedge clk) begin
    if (opnd_rd_en) opnd_rd_data <= opnd_rd_sel ? buf_b[opnd_rd_row[0]] : buf_a[opnd_rd_row[0]];
    else            opnd_rd_data <= 6'd0;
  end

  // Multiplier model: accumulator cleared by mul_clear, result one cycle after the row
  always @(posedge clk) begin
    if (rst || mul_clear) begin
      ma[0] <= 6'd0; ma[1] <= 6'd0; mb[0] <= 6'd0; mb[1] <= 6'd0; mul_res <= 6'd0;
    end else if (mul_en) begin
      if (!mul_sel && mul_row <= 2'd1) ma[mul_row[0]] <= mul_entry;
      if (mul_sel) mb[mul_row[0]] <= mul_entry;
      mul_res <= conv(mul_row, ma[0], ma[1],
                      (mul_sel && mul_row == 2'd0) ? mul_entry : mb[0],
                      (mul_sel && mul_row == 2'd1) ? mul_entry : mb[1]);
    end
  end

  always @(negedge clk) if (done) done_seen <= done_seen + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(logic clr, logic bsy, logic rd, logic rsel, logic [1:0] rrow,
                                     logic men, logic [1:0] mrow, logic msel, logic [5:0] ent,
                                     logic wen, logic [1:0] wrow, logic [5:0] wd, logic dn);
    return {6'd0, clr, bsy, rd, rsel, rrow, men, mrow, msel, ent, wen, wrow, wd, dn};
  endfunction

  function automatic logic [31:0] obs();
    return pk(mul_clear, busy, opnd_rd_en, opnd_rd_sel, opnd_rd_row, mul_en, mul_row, mul_sel,
              mul_entry, res_wr_en, res_wr_row, res_wr_data, done);
  endfunction

  // Hand-derived output table for A=(26,36), B=(31,21); mode 2 aborts in cycle 5
  function automatic logic [31:0] exp_vec(int mode, int c);
    if (mode == 2 && c == 6) return pk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b0);
    if (mode == 2 && c > 6)  return 32'd0;
    case (c)
      1: return pk(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 6'd0,  1'b0, 2'd0, 6'd0,  1'b0);
      2: return pk(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 6'd0,  1'b0, 2'd0, 6'd0,  1'b0);
      3: return pk(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 2'd0, 1'b0, 6'd26, 1'b0, 2'd0, 6'd0,  1'b0);
      4: return pk(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 2'd1, 1'b0, 6'd36, 1'b0, 2'd0, 6'd0,  1'b0);
      5: return pk(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 1'b1, 6'd31, 1'b0, 2'd0, 6'd0,  1'b0);
      6: return pk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 6'd21, 1'b1, 2'd0, 6'd38, 1'b0);
      7: return pk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 6'd0,  1'b1, 2'd1, 6'd62, 1'b0);
      8: return pk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 6'd0,  1'b1, 2'd2, 6'd52, 1'b0);
      9: return pk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 6'd0,  1'b0, 2'd0, 6'd0,  1'b1);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [15:0] exp_count();
`ifdef HE_SEQ_OP_COUNT_EN
    return op_exp;
`else
    return 16'h0000;
`endif
  endfunction

  // Called at a negedge: that cycle is cycle 0. mode 0 nominal, 1 start-while-busy, 2 abort, 3 reset
  task automatic run_op(input int mode, input bit chain);
    done_base = done_seen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check_eq($sformatf("m%0d_cyc%0d", mode, c), obs(), exp_vec(mode, c));
      if (mode == 1) start = (c == 4);
      if (mode == 2) abort = (c == 5);
      if (mode == 3 && c == 7) begin
        rst = 1'b1;
        #1;
        check_eq("rst_async_out", obs(), 32'd0);
        op_exp = 16'h0000;
        check_eq("rst_async_cnt", {16'd0, op_count}, {16'd0, exp_count()});
        #3 rst = 1'b0;
        check_eq("rst_no_done", done_seen - done_base, 0);
        return;
      end
      if (chain && c == 10) break;
      @(negedge clk);
    end
    if (mode <= 1 && op_exp != 16'hFFFF) op_exp = op_exp + 16'h0001;
    check_eq($sformatf("m%0d_done_cnt", mode), done_seen - done_base, (mode <= 1) ? 1 : 0);
    check_eq($sformatf("m%0d_op_count", mode), {16'd0, op_count}, {16'd0, exp_count()});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    buf_a[0] = 6'd26; buf_a[1] = 6'd36; buf_b[0] = 6'd31; buf_b[1] = 6'd21;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_out", obs(), 32'd0);
    check_eq("reset_cnt", {16'd0, op_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(0, 1'b1);
    run_op(0, 1'b0);
    @(negedge clk);
    run_op(1, 1'b0);
    @(negedge clk);
    run_op(2, 1'b0);
    // start together with abort in IDLE must not start
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("start_abort_idle", obs(), 32'd0);
    @(negedge clk);
    check_eq("start_abort_idle2", obs(), 32'd0);
    run_op(3, 1'b0);
    @(negedge clk);
    run_op(0, 1'b0);
`ifdef HE_SEQ_OP_COUNT_EN
    @(negedge clk);
    force dut.op_count_r = 16'hFFFE;
    @(negedge clk);
    release dut.op_count_r;
    op_exp = 16'hFFFE;
    run_op(0, 1'b0);
    run_op(0, 1'b0);
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/he_mul_sequencer.md
Name: he_mul_sequencer

Overview:
- Control FSM that sequences one homomorphic multiply on the `homomorphic_multiply` datapath.
- On a start pulse it does four things in order:
  - clears the multiplier accumulator;
  - streams ciphertext A rows (select 0), then ciphertext B rows (select 1), from a registered operand buffer into the multiplier;
  - drains the upper tensor rows;
  - writes all 2*DIMENSION+1 result rows to a result buffer.
- Sits between the operand/result buffers and the multiplier; later feeds the decrypt row stream.

Parameters:
- CIPHERTEXT_WIDTH, 6, bits per ciphertext entry.
- DIMENSION, 1, LWE dimension; ciphertexts have DIMENSION+1 rows, results have 2*DIMENSION+1 rows.
- ROW_WIDTH, 2, width of every row index; must hold 2*DIMENSION.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins an operation when sampled in IDLE.
- abort  in  1  cancels the operation in progress.
- opnd_rd_en  out  1  operand buffer read strobe.
- opnd_rd_sel  out  1  0 = ciphertext A, 1 = ciphertext B.
- opnd_rd_row  out  ROW_WIDTH  operand row address.
- opnd_rd_data  in  CIPHERTEXT_WIDTH  operand data, valid the cycle after opnd_rd_en.
- mul_clear  out  1  one-cycle accumulator clear; integrator drives multiplier rst_n = ~(rst | mul_clear).
- mul_en  out  1  multiplier enable.
- mul_row  out  ROW_WIDTH  multiplier row.
- mul_ciphertext_select  out  1  multiplier ciphertext select.
- mul_ciphertext_entry  out  CIPHERTEXT_WIDTH  multiplier data input.
- mul_result_partial  in  CIPHERTEXT_WIDTH  multiplier result, valid the cycle after the row is presented.
- res_wr_en  out  1  result buffer write strobe.
- res_wr_row  out  ROW_WIDTH  result row address.
- res_wr_data  out  CIPHERTEXT_WIDTH  result data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at successful completion.
- op_count  out  16  completed-operation count (optional feature).

Behaviour:
- Reset: state IDLE; all outputs and internal counters 0.
- State sequence: IDLE -> CLEAR -> LOAD_A -> LOAD_B -> DRAIN -> FLUSH -> DONE -> IDLE.
- Cycle numbering: cycle 0 is the cycle in which start is sampled high in IDLE; D = DIMENSION.
- Cycle 1, CLEAR: mul_clear=1; all other outputs 0.
- Operand reads, cycles 2..2D+3: opnd_rd_en=1.
  - LOAD_A, cycles 2..D+2: sel=0, row 0..D.
  - LOAD_B, cycles D+3..2D+3: sel=1, row 0..D.
- Multiplier drive, one cycle behind each read, cycles 3..2D+4:
  - mul_en=1;
  - mul_row and mul_ciphertext_select = delayed read row/sel;
  - mul_ciphertext_entry = opnd_rd_data.
- DRAIN, cycles 2D+5..3D+4:
  - mul_en=1, select 0, entry 0;
  - mul_row = D+1..2D.
- Result writes, one per cycle, cycles D+5..3D+5:
  - res_wr_en=1, res_wr_data = mul_result_partial;
  - res_wr_row = 0..2D (rows 0..D one cycle after each B row; rows D+1..2D one cycle after each drain row).
- FLUSH: covers the final write cycle.
- DONE, cycle 3D+6: done=1. Next cycle: IDLE.
- Total latency from start to done is 3D+6 cycles (9 for D=1).
- mul_en stays 0 outside the drive windows; mul_row and select are held at 0 when idle.
- start while busy: ignored; no queuing.
- abort (highest priority after rst), sampled high in any non-IDLE state:
  - next cycle goes to IDLE;
  - that cycle drives mul_clear=1, all strobes 0, no done;
  - partial result rows already written stay written.
- start and abort high together in IDLE: abort wins; nothing starts.
- rst mid-operation: immediate return to reset values; op_count cleared.
- Row counters must not wrap. Each state exits when its counter reaches its terminal value (D or 2D).
- Arithmetic: none. Data passes through unmodified at full CIPHERTEXT_WIDTH.

Optional Feature:
- Macro: HE_SEQ_OP_COUNT_EN.
- Defined:
  - op_count increments by 1 in the cycle done pulses;
  - saturates at 16'hFFFF;
  - not incremented on abort;
  - cleared only by rst.
- Undefined: op_count tied to 0; no counter flops.

Test Plan:
- Nominal, D=1: buffer A=(26,36), B=(31,21); start at cycle 0 -> mul_clear at cycle 1; result writes row0=38 (cycle 6), row1=62 (cycle 7), row2=52 (cycle 8); done at cycle 9; busy high cycles 1-9.
- Back-to-back: second start pulse on the cycle after done -> identical results; accumulator cleared, no carry-over; op_count=2 with the macro defined, 0 without.
- Start while busy: pulse start at cycle 4 -> ignored; sequence and done timing unchanged; exactly one done.
- Abort: assert abort at cycle 5 (LOAD_B) -> cycle 6 is IDLE with mul_clear=1; res_wr_en never asserted; no done; op_count unchanged.
- Async reset: assert rst at cycle 7 mid-drain -> all outputs 0 immediately; after release, a fresh start reproduces 38/62/52.
- Saturation (macro defined): force op_count to 16'hFFFE, run 2 ops -> op_count 16'hFFFF, then stays 16'hFFFF.
